// File: rtl/sample_writer.sv
// Triggered sample capture into a RAM write port.
// Arm latches the start address and sample count, a trigger opens the
// capture window, and every accepted sample becomes one registered RAM write.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for arm; nothing captured since reset or abort
// ST_ARMED    | start_addr/length latched, waiting for trig
// ST_CAPTURE  | din_ready high, each valid sample becomes a write
// ST_DONE     | target count reached; holds until re-armed
module sample_writer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  trig,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  din_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    // A length of zero stands for a full sweep of the address space.
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   target;
    logic                  load;
    logic                  accept;

    // Next-state decode plus the load/accept strobes that drive the datapath.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    load       = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (abort)
                    state_next = ST_IDLE;
                else if (trig)
                    state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (din_valid) begin
                    accept = 1'b1;
                    // wr_count already includes every earlier acceptance, so
                    // this sample is the last one when count+1 hits the target.
                    if ((wr_count + COUNT_ONE) == target)
                        state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign din_ready = (state == ST_CAPTURE);
    assign busy      = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign done      = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Write pointer, target, registered RAM port and sample counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            target   <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_count <= '0;
        end else begin
            wr_en <= accept;
            if (load) begin
                ptr      <= start_addr;
                target   <= (length == '0) ? COUNT_FULL : {1'b0, length};
                wr_count <= '0;
            end
            if (accept) begin
                wr_addr  <= ptr;
                wr_data  <= din;
                ptr      <= ptr + 1'b1;
                wr_count <= wr_count + COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sample_writer.sv
// Bench for sample_writer: directed scenarios with literal expectations,
// then a long randomized run, all checked cycle by cycle against a
// behavioural capture model.
module tb_sample_writer;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          trig;
    logic          abort;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] length;
    logic          din_valid;
    logic [DW-1:0] din;
    logic          din_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];

    sample_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .trig       (trig),
        .abort      (abort),
        .start_addr (start_addr),
        .length     (length),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase of the capture plus samples still owed.
    localparam int P_IDLE = 0, P_WAIT_TRIG = 1, P_RUN = 2, P_FINISHED = 3;
    int            m_phase = P_IDLE;
    int            m_remaining = 0;
    int            m_ptr = 0;
    int            m_count = 0;
    bit            m_wr_en = 1'b0;
    int            m_addr = 0;
    int            m_data = 0;

    always @(posedge clk) begin
        m_wr_en <= 1'b0;
        if (!rst) begin
            m_phase     <= P_IDLE;
            m_count     <= 0;
            m_addr      <= 0;
            m_data      <= 0;
            m_ptr       <= 0;
            m_remaining <= 0;
        end else begin
            case (m_phase)
                P_IDLE, P_FINISHED: begin
                    if (arm) begin
                        m_ptr       <= int'(start_addr);
                        m_remaining <= (length == 0) ? DEPTH : int'(length);
                        m_count     <= 0;
                        m_phase     <= P_WAIT_TRIG;
                    end
                end
                P_WAIT_TRIG: begin
                    if (abort)     m_phase <= P_IDLE;
                    else if (trig) m_phase <= P_RUN;
                end
                default: begin
                    if (abort) begin
                        m_phase <= P_IDLE;
                    end else if (din_valid) begin
                        m_wr_en     <= 1'b1;
                        m_addr      <= m_ptr;
                        m_data      <= int'(din);
                        m_ptr       <= (m_ptr + 1) % DEPTH;
                        m_count     <= m_count + 1;
                        m_remaining <= m_remaining - 1;
                        if (m_remaining == 1) m_phase <= P_FINISHED;
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model away from the active edge; log writes.
    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_en", int'(wr_en), int'(m_wr_en));
            check("busy", int'(busy), int'(m_phase == P_WAIT_TRIG || m_phase == P_RUN));
            check("done", int'(done), int'(m_phase == P_FINISHED));
            check("din_ready", int'(din_ready), int'(m_phase == P_RUN));
            check("wr_count", int'(wr_count), m_count);
            if (m_wr_en) begin
                check("wr_addr", int'(wr_addr), m_addr);
                check("wr_data", int'(wr_data), m_data);
            end
            if (wr_en === 1'b1) begin
                log_addr.push_back(wr_addr);
                log_data.push_back(wr_data);
            end
        end
    end

    task automatic drive(input bit r, input bit a, input bit t, input bit ab,
                         input bit v, input logic [DW-1:0] d);
        rst       = r;
        arm       = a;
        trig      = t;
        abort     = ab;
        din_valid = v;
        din       = d;
        @(negedge clk);
        #1;
    endtask

    task automatic arm_with(input logic [AW-1:0] sa, input logic [AW-1:0] len);
        start_addr = sa;
        length     = len;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        bit            seen[DEPTH];
        int            missing;
        bit            vpat[6];

        rst = 1'b0; arm = 1'b1; trig = 1'b1; abort = 1'b0;
        din_valid = 1'b1; din = 8'hFF; start_addr = 8'h33; length = 8'h05;
        chk_en = 1'b1;

        // Reset held with every control input active.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_wr_count", int'(wr_count), 0);
        check("rst_busy_done_ready", int'({busy, done, din_ready}), 0);
        clear_log();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Basic back-to-back capture of four samples.
        arm_with(8'h10, 8'd4);
        check("basic_armed_busy", int'(busy), 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DW'(8'hA1 + i));
        check("basic_done_with_last", int'({done, wr_en}), 3);
        check("basic_last_addr", int'(wr_addr), 'h13);
        check("basic_count", int'(wr_count), 4);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hEE);
        check("basic_nwrites", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check("basic_addr", int'(log_addr[i]), 'h10 + i);
            check("basic_data", int'(log_data[i]), 'hA1 + i);
        end
        check("basic_done_holds", int'(done), 1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        check("abort_in_done_ignored", int'(done), 1);

        // Address wrap with gaps in din_valid.
        clear_log();
        arm_with(8'hFE, 8'd4);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        vpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, vpat[i], DW'(8'hB0 + i));
        check("wrap_nwrites", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            check("wrap_a0", int'(log_addr[0]), 'hFE);
            check("wrap_a1", int'(log_addr[1]), 'hFF);
            check("wrap_a2", int'(log_addr[2]), 'h00);
            check("wrap_a3", int'(log_addr[3]), 'h01);
            check("wrap_d1", int'(log_data[1]), 'hB2);
            check("wrap_d3", int'(log_data[3]), 'hB5);
        end
        check("wrap_done", int'(done), 1);

        // Sample presented together with trig is not captured.
        clear_log();
        arm_with(8'h20, 8'd2);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77);
        check("trig_nwrites", log_addr.size(), 2);
        if (log_addr.size() >= 1) begin
            check("trig_first_addr", int'(log_addr[0]), 'h20);
            check("trig_first_data", int'(log_data[0]), 'h66);
        end

        // Abort after three samples, with a valid sample alongside abort.
        clear_log();
        arm_with(8'h40, 8'd8);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, DW'(8'hC0 + i));
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3);
        check("abort_state", int'({busy, done, din_ready}), 0);
        check("abort_count", int'(wr_count), 3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC4);
        check("abort_nwrites", log_addr.size(), 3);

        // Reset in the middle of a capture.
        clear_log();
        arm_with(8'h50, 8'd8);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hD0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hD1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD2);
        check("midrst_quiet", int'({wr_en, busy, done}), 0);
        check("midrst_count", int'(wr_count), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hD3);
        check("midrst_nwrites", log_addr.size(), 2);

        // Full depth with length zero, then re-arm.
        clear_log();
        arm_with(8'h37, 8'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            d = DW'(i) ^ 8'h5A;
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, d);
        end
        check("full_done", int'(done), 1);
        check("full_count", int'(wr_count), DEPTH);
        check("full_nwrites", log_addr.size(), DEPTH);
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (log_addr[i]) seen[log_addr[i]] = 1'b1;
        missing = 0;
        foreach (seen[i]) if (!seen[i]) missing++;
        check("full_missing_addrs", missing, 0);
        arm_with(8'h00, 8'd3);
        check("rearm_busy", int'({busy, done}), 2);
        check("rearm_count", int'(wr_count), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            start_addr = AW'($urandom);
            length     = ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, 12));
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 1) == 1),
                  DW'($urandom));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
